dmem_arbiter: RTL and testbench

- Shares the single-port data RAM between the pipeline MEM stage (CPU port) and an external requester (program loader / debug / DMA port, EXT).
- Sits between the EX/MEM outputs and the data RAM instance; drives the RAM control, address and write-data pins.
- Returns stall to the hazard logic when the CPU is denied a cycle.
- CPU has priority; a starvation counter guarantees EXT forward progress.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_starve_ctr.sv | 32 +++
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter: FSM encoding and parameter defaults.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_W       = 32;
  localparam int unsigned DMEM_DATA_W       = 32;
  localparam int unsigned DMEM_STARVE_LIMIT = 4;
  // Wide enough for the largest legal STARVE_LIMIT (15)
  localparam int unsigned DMEM_STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT_ACC = 2'd1,
    EXT_ACK = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating count of consecutive cycles the EXT requester lost to the CPU.
// at_limit tells the arbiter that EXT must go ahead of the CPU on this cycle.
module dmem_starve_ctr
  import dmem_pkg::*;
#(
  parameter int unsigned LIMIT = DMEM_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [DMEM_STARVE_CNT_W-1:0] LIMIT_C = DMEM_STARVE_CNT_W'(LIMIT);

  logic [DMEM_STARVE_CNT_W-1:0] cnt_q;

  // clr wins over inc so a grant and a loss can never both land in the count
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != LIMIT_C)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign at_limit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the MEM stage (priority) and an external requester.
// Optional DMEM_ARB_STATS_EN adds wrapping stall/grant counters with a synchronous clear.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W       = DMEM_ADDR_W,
  parameter int unsigned DATA_W       = DMEM_DATA_W,
  parameter int unsigned STARVE_LIMIT = DMEM_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef DMEM_ARB_STATS_EN
  input  logic              stat_clr,
  output logic [31:0]       stat_cpu_stalls,
  output logic [31:0]       stat_ext_grants,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state_q, state_d;
  logic       cpu_req;
  logic       at_limit;
  logic       ext_grant;
  logic       starve_inc;
  logic       starve_clr;

  assign cpu_req = cpu_read | cpu_write;

  dmem_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The CPU owns the bus by default; only EXT_ACC hands it to the external port.
  always_comb begin
    state_d    = state_q;
    ext_grant  = 1'b0;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    mem_read   = cpu_read;
    mem_write  = cpu_write;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    cpu_stall  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ext_req && (!cpu_req || at_limit)) begin
          ext_grant  = 1'b1;
          starve_clr = 1'b1;
          state_d    = EXT_ACC;
        end else if (ext_req) begin
          starve_inc = 1'b1;
        end else begin
          starve_clr = 1'b1;
        end
      end
      EXT_ACC: begin
        mem_read  = !ext_we;
        mem_write = ext_we;
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
        cpu_stall = cpu_req;
        state_d   = EXT_ACK;
      end
      EXT_ACK: begin
        starve_clr = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_rdata <= '0;
    end else if (state_q == EXT_ACC) begin
      ext_rdata <= mem_rdata;
    end
  end

  assign ext_ack   = (state_q == EXT_ACK);
  assign cpu_rdata = mem_rdata;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_cpu_stalls <= '0;
      stat_ext_grants <= '0;
    end else begin
      if (cpu_stall) begin
        stat_cpu_stalls <= stat_cpu_stalls + 32'd1;
      end
      if (ext_grant) begin
        stat_ext_grants <= stat_ext_grants + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: RAM model, shadow memory and a per-transaction arbitration predictor.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_read, cpu_write;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata, ext_rdata;
  logic          ext_ack;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic          stat_clr;
  logic [31:0]   stat_cpu_stalls, stat_ext_grants;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
`ifdef DMEM_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_cpu_stalls(stat_cpu_stalls), .stat_ext_grants(stat_ext_grants),
`endif
    .mem_rdata(mem_rdata)
  );

  // 64-word RAM: combinational read, write on the clock edge
  logic [DW-1:0] ram [0:63];
  logic          ram_init;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= '0;
    end else if (mem_write) begin
      ram[mem_addr[7:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = ram[mem_addr[7:2]];

  logic [DW-1:0] shadow [0:63];
  int tests = 0;
  int fails = 0;

  // CPU op script for one EXT transaction: 0 idle, 1 load, 2 store
  int            op_kind  [0:15];
  logic [AW-1:0] op_addr  [0:15];
  logic [DW-1:0] op_wdata [0:15];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_cpu(input int kind, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    cpu_read  = (kind == 1);
    cpu_write = (kind == 2);
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  task automatic clear_ops();
    for (int i = 0; i < 16; i++) begin
      op_kind[i]  = 0;
      op_addr[i]  = '0;
      op_wdata[i] = '0;
    end
  endtask

  // One CPU-only cycle; the CPU must never be stalled with no EXT activity.
  task automatic cpu_only(input int kind, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    logic [AW-1:0] a;
    a = addr;
    drive_cpu(kind, addr, wdata);
    @(negedge clk);
    chk("cpu_only_stall", cpu_stall, 1'b0);
    chk("cpu_only_ack", ext_ack, 1'b0);
    if (kind == 1) chk("cpu_only_rdata", cpu_rdata, shadow[a[7:2]]);
    @(posedge clk);
    if (kind == 2) shadow[a[7:2]] = wdata;
    #1;
    drive_cpu(0, '0, '0);
  endtask

  // EXT wins in the first script cycle where the CPU is idle, or after LIM lost cycles;
  // the access occupies the next cycle and the ack follows one cycle later.
  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic drop_early, output int stalls);
    int            k;
    int            idx;
    logic          exp_stall;
    logic [DW-1:0] exp_rd;
    logic [AW-1:0] a;
    k = LIM;
    for (int i = LIM - 1; i >= 0; i--) if (op_kind[i] == 0) k = i;
    idx = 0;
    stalls = 0;
    exp_rd = '0;
    ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_wdata = wdata;
    for (int cyc = 0; cyc <= k + 2; cyc++) begin
      if (drop_early && cyc == k + 1) ext_req = 1'b0;
      a = op_addr[idx];
      drive_cpu(op_kind[idx], op_addr[idx], op_wdata[idx]);
      @(negedge clk);
      exp_stall = (cyc == k + 1) && (op_kind[idx] != 0);
      chk("cpu_stall", cpu_stall, exp_stall);
      chk("ext_ack", ext_ack, cyc == k + 2);
      chk("mem_write", mem_write, (cyc == k + 1) ? we : (op_kind[idx] == 2));
      if (!exp_stall && op_kind[idx] == 1) chk("cpu_rdata", cpu_rdata, shadow[a[7:2]]);
      if (cyc == k + 1) exp_rd = shadow[addr[7:2]];
      if (cyc == k + 2 && !we) chk("ext_rdata", ext_rdata, exp_rd);
      @(posedge clk);
      if (cyc == k + 1) begin
        if (we) shadow[addr[7:2]] = wdata;
      end else if (op_kind[idx] == 2) begin
        shadow[a[7:2]] = op_wdata[idx];
      end
      if (exp_stall) stalls++;
      else idx++;
      #1;
    end
    ext_req = 1'b0;
    drive_cpu(0, '0, '0);
  endtask

  initial begin
    int            st;
    int            exp_stalls;
    int            r;
    logic [AW-1:0] ra;

    rst = 1'b1; ram_init = 1'b1;
    drive_cpu(0, '0, '0);
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
`ifdef DMEM_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    for (int i = 0; i < 64; i++) shadow[i] = '0;
    clear_ops();
    @(posedge clk);
    @(negedge clk);
    chk("rst_ext_ack", ext_ack, 1'b0);
    chk("rst_ext_rdata", ext_rdata, 32'h0);
    chk("rst_cpu_stall", cpu_stall, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_read", mem_read, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; ram_init = 1'b0;

    // CPU only
    cpu_only(2, 32'h10, 32'hDEADBEEF);
    cpu_only(1, 32'h10, 32'h0);
    chk("cpu_only_shadow", shadow[4], 32'hDEADBEEF);

    // EXT only, read of a preloaded word
    cpu_only(2, 32'h20, 32'h12345678);
    clear_ops();
    run_txn(1'b0, 32'h20, 32'h0, 1'b0, st);
    chk("ext_only_rdata", ext_rdata, 32'h12345678);

    // Reset while the EXT access is in flight
    clear_ops();
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h10;
    @(negedge clk);
    chk("mid_rst_grant_ack", ext_ack, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_acc_read", mem_read, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0; ext_req = 1'b0;
    @(negedge clk);
    chk("mid_rst_mem_read", mem_read, 1'b0);
    chk("mid_rst_ext_rdata", ext_rdata, 32'h0);
    chk("mid_rst_starve_cnt", 32'(dut.u_starve.cnt_q), 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_no_ack", ext_ack, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;

    // Starvation: CPU loads every cycle
    clear_ops();
    for (int i = 0; i < 16; i++) begin op_kind[i] = 1; op_addr[i] = 32'h30; end
    run_txn(1'b1, 32'h30, 32'hA5A5A5A5, 1'b0, st);
    cpu_only(1, 32'h30, 32'h0);
    chk("starve_readback", shadow[12], 32'hA5A5A5A5);

    // Collision: CPU store and EXT store raised in the same cycle
    clear_ops();
    op_kind[0] = 2; op_addr[0] = 32'h40; op_wdata[0] = 32'h11112222;
    run_txn(1'b1, 32'h44, 32'h33334444, 1'b0, st);
    cpu_only(1, 32'h40, 32'h0);
    cpu_only(1, 32'h44, 32'h0);

    // ext_req withdrawn after the grant: the access still completes
    clear_ops();
    op_kind[0] = 1; op_addr[0] = 32'h44;
    run_txn(1'b0, 32'h40, 32'h0, 1'b1, st);

    // Randomized transactions against the shadow memory
    for (int t = 0; t < 24; t++) begin
      clear_ops();
      for (int i = 0; i < 16; i++) begin
        r = $urandom_range(0, 3);
        op_kind[i]  = (r == 0) ? 0 : ((r == 1) ? 2 : 1);
        op_addr[i]  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        op_wdata[i] = $urandom;
      end
      ra = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      run_txn(1'($urandom_range(0, 1)), ra, $urandom, 1'b0, st);
    end
    for (int i = 0; i < 64; i++) cpu_only(1, 32'(i * 4), 32'h0);

`ifdef DMEM_ARB_STATS_EN
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    exp_stalls = 0;
    clear_ops();
    for (int i = 0; i < 16; i++) begin op_kind[i] = 1; op_addr[i] = 32'h30; end
    for (int n = 0; n < 3; n++) begin
      run_txn(1'b1, 32'h30, 32'hA5A5A5A5, 1'b0, st);
      exp_stalls += st;
    end
    @(negedge clk);
    chk("stat_ext_grants", stat_ext_grants, 32'd3);
    chk("stat_cpu_stalls", stat_cpu_stalls, 32'(exp_stalls));
    chk("stat_cpu_stalls_3", stat_cpu_stalls, 32'd3);
    @(posedge clk); #1;
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    @(negedge clk);
    chk("stat_clr_grants", stat_ext_grants, 32'd0);
    chk("stat_clr_stalls", stat_cpu_stalls, 32'd0);
`else
    exp_stalls = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
